// File: rtl/spi_slave_gen.sv
// Parametrised SPI slave front-end for the single-port RAM subsystem.
// Deserialises {cmd, payload} MOSI frames and serialises RAM read data on MISO.
module spi_slave_gen #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                MOSI,
  input  logic                tx_valid,
  input  logic [DATA_W-1:0]   tx_data,
  output logic                MISO,
  output logic                rx_valid,
  output logic [DATA_W+1:0]   rx_data,
  output logic                frame_err,
  output logic                miso_busy
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TO_W    = $clog2(TX_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(DATA_W);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    WAIT_TX,
    SHIFT_OUT,
    DONE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [TO_W-1:0]    to_cnt, to_cnt_n;
  logic [FRAME_W-2:0] shreg, shreg_n;
  logic [DATA_W-1:0]  tx_sh, tx_sh_n;
  logic               rd_addr_rcvd, rd_addr_n;
  logic               miso_n, rx_valid_n, frame_err_n, busy_n;
  logic [FRAME_W-1:0] rx_data_n;

  logic [FRAME_W-1:0] frame_bits;
  logic [1:0]         cmd;
  logic               legal;

  assign frame_bits = {shreg, MOSI};
  assign cmd        = frame_bits[FRAME_W-1:FRAME_W-2];

  always_comb begin
    case (state)
      WRITE:     legal = ~cmd[1];
      READ_ADD:  legal = (cmd == 2'b10);
      READ_DATA: legal = (cmd == 2'b11);
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    to_cnt_n    = to_cnt;
    shreg_n     = shreg;
    tx_sh_n     = tx_sh;
    rd_addr_n   = rd_addr_rcvd;
    rx_data_n   = rx_data;
    miso_n      = 1'b0;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    busy_n      = 1'b0;

    case (state)
      IDLE: begin
        bit_cnt_n = '0;
        to_cnt_n  = '0;
        if (!SS_n) state_n = CHK_CMD;
      end

      CHK_CMD: begin
        if (SS_n) begin
          state_n     = IDLE;
          frame_err_n = 1'b1;
          bit_cnt_n   = '0;
          to_cnt_n    = '0;
        end else begin
          shreg_n   = '0;
          bit_cnt_n = '0;
          if (!MOSI)             state_n = WRITE;
          else if (rd_addr_rcvd) state_n = READ_DATA;
          else                   state_n = READ_ADD;
        end
      end

      WRITE, READ_ADD, READ_DATA: begin
        // The last bit wins over a simultaneous SS_n release: the frame completes.
        if (bit_cnt == LAST_BIT) begin
          rx_data_n   = frame_bits;
          rx_valid_n  = legal;
          frame_err_n = ~legal;
          bit_cnt_n   = '0;
          to_cnt_n    = '0;
          if (state == READ_ADD && legal) rd_addr_n = 1'b1;
          if (SS_n)                             state_n = IDLE;
          else if (state == READ_DATA && legal) state_n = WAIT_TX;
          else                                  state_n = DONE;
        end else if (SS_n) begin
          state_n     = IDLE;
          frame_err_n = 1'b1;
          bit_cnt_n   = '0;
          to_cnt_n    = '0;
        end else begin
          shreg_n   = frame_bits[FRAME_W-2:0];
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end

      WAIT_TX: begin
        if (SS_n) begin
          state_n     = IDLE;
          frame_err_n = 1'b1;
          bit_cnt_n   = '0;
          to_cnt_n    = '0;
        end else if (tx_valid) begin
          // MSB goes straight to MISO; bit_cnt counts bits already presented.
          tx_sh_n   = tx_data << 1;
          miso_n    = tx_data[DATA_W-1];
          busy_n    = 1'b1;
          bit_cnt_n = CNT_W'(1);
          to_cnt_n  = '0;
          state_n   = SHIFT_OUT;
        end else if (to_cnt == TO_LAST) begin
          frame_err_n = 1'b1;
          to_cnt_n    = '0;
          state_n     = DONE;
        end else begin
          to_cnt_n = (to_cnt == '1) ? to_cnt : to_cnt + TO_W'(1);
        end
      end

      SHIFT_OUT: begin
        if (SS_n) begin
          state_n     = IDLE;
          frame_err_n = 1'b1;
          bit_cnt_n   = '0;
          to_cnt_n    = '0;
          rd_addr_n   = 1'b0;
        end else if (bit_cnt == OUT_LAST) begin
          bit_cnt_n = '0;
          rd_addr_n = 1'b0;
          state_n   = DONE;
        end else begin
          miso_n    = tx_sh[DATA_W-1];
          tx_sh_n   = tx_sh << 1;
          busy_n    = 1'b1;
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end

      DONE: begin
        bit_cnt_n = '0;
        to_cnt_n  = '0;
        if (SS_n) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      shreg        <= '0;
      tx_sh        <= '0;
      rd_addr_rcvd <= 1'b0;
      rx_data      <= '0;
      MISO         <= 1'b0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      miso_busy    <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      to_cnt       <= to_cnt_n;
      shreg        <= shreg_n;
      tx_sh        <= tx_sh_n;
      rd_addr_rcvd <= rd_addr_n;
      rx_data      <= rx_data_n;
      MISO         <= miso_n;
      rx_valid     <= rx_valid_n;
      frame_err    <= frame_err_n;
      miso_busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_spi_slave_gen.sv
// Self-checking bench for spi_slave_gen (DATA_W=8): frame vector table plus
// hand sequences for readout, timeout and reset; event/MISO scoreboards.
module tb_spi_slave_gen;

  localparam int DATA_W     = 8;
  localparam int TX_TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              SS_n;
  logic              MOSI;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              MISO;
  logic              rx_valid;
  logic [DATA_W+1:0] rx_data;
  logic              frame_err;
  logic              miso_busy;

  spi_slave_gen #(.DATA_W(DATA_W), .TX_TIMEOUT(TX_TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .MISO      (MISO),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .miso_busy (miso_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    bit         chk_data;
    logic [9:0] data;
  } ev_t;

  typedef struct {
    bit         dir;
    logic [9:0] bits;
    int         nbits;
    bit         ss_at_last;
    bit         exp_err;
    bit         chk_data;
  } vec_t;

  ev_t  exp_q[$];
  logic miso_q[$];
  ev_t  ev_m;
  int   n_checks = 0;
  int   n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input bit is_err, input bit chk, input logic [9:0] d);
    ev_t e;
    e.is_err   = is_err;
    e.chk_data = chk;
    e.data     = d;
    exp_q.push_back(e);
  endtask

  task automatic push_miso(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) miso_q.push_back(d[i]);
  endtask

  task automatic run_frame(input bit dir, input logic [9:0] bits, input int nbits,
                           input bit ss_at_last, input bit release_after);
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
    @(negedge clk); MOSI = dir;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      MOSI = bits[9-i];
      if (i == nbits - 1 && ss_at_last) SS_n = 1'b1;
    end
    @(negedge clk); MOSI = 1'b0;
    if (release_after) SS_n = 1'b1;
  endtask

  // Event and MISO monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rx_err_excl", {31'd0, rx_valid & frame_err}, 0);
      if (rx_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_evt", {30'd0, rx_valid, frame_err}, 0);
        end else begin
          ev_m = exp_q.pop_front();
          check("evt_kind", {30'd0, rx_valid, frame_err}, ev_m.is_err ? 32'd1 : 32'd2);
          if (ev_m.chk_data) check("rx_data", {22'd0, rx_data}, {22'd0, ev_m.data});
        end
      end
      if (miso_busy) begin
        if (miso_q.size() == 0) check("extra_busy", {31'd0, miso_busy}, 0);
        else                    check("miso_bit", {31'd0, MISO}, {31'd0, miso_q.pop_front()});
      end else begin
        check("miso_idle", {31'd0, MISO}, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[10];
  int   k;

  initial begin
    vecs[0] = '{1'b0, 10'h0A5, 10, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 10'h1FF, 10, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 10'h2AA, 10, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 10'h33C, 10, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 10'h155, 10, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 10'h3FF, 10, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 10'h0F0,  4, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 10'h000, 10, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 10'h0C3, 10, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 10'h210, 10, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (2) @(negedge clk);
    check("rst_miso", {31'd0, MISO}, 0);
    check("rst_rx_valid", {31'd0, rx_valid}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    check("rst_busy", {31'd0, miso_busy}, 0);
    check("rst_rx_data", {22'd0, rx_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // tx_valid held high through the table must not start a readout
    tx_valid = 1'b1; tx_data = 8'hFF;
    foreach (vecs[i]) begin
      push_ev(vecs[i].exp_err, vecs[i].chk_data, vecs[i].bits);
      run_frame(vecs[i].dir, vecs[i].bits, vecs[i].nbits, vecs[i].ss_at_last, 1'b1);
      repeat (3) @(negedge clk);
      check("vec_pending", exp_q.size(), 0);
    end
    tx_valid = 1'b0; tx_data = '0;

    // Read-data frame followed by readout of 8'hC3
    push_ev(1'b0, 1'b1, 10'h3A7);
    run_frame(1'b1, 10'h3A7, 10, 1'b0, 1'b0);
    push_miso(8'hC3);
    tx_valid = 1'b1; tx_data = 8'hC3;
    @(negedge clk); tx_valid = 1'b0; tx_data = '0;
    repeat (10) @(negedge clk);
    check("readout_left", miso_q.size(), 0);
    SS_n = 1'b1;
    repeat (2) @(negedge clk);
    check("readout_pending", exp_q.size(), 0);

    // rd_addr_rcvd cleared: address frame accepted, then tx_valid withheld
    push_ev(1'b0, 1'b1, 10'h245);
    run_frame(1'b1, 10'h245, 10, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    push_ev(1'b0, 1'b1, 10'h3C0);
    push_ev(1'b1, 1'b0, 10'h000);
    run_frame(1'b1, 10'h3C0, 10, 1'b0, 1'b0);
    k = 1;
    while (k <= 40) begin
      @(negedge clk);
      if (frame_err) break;
      k++;
    end
    check("timeout_latency", k, TX_TIMEOUT);
    SS_n = 1'b1;
    repeat (2) @(negedge clk);
    check("timeout_pending", exp_q.size(), 0);

    // Address still held: a cmd 11 frame is legal straight away
    push_ev(1'b0, 1'b1, 10'h311);
    run_frame(1'b1, 10'h311, 10, 1'b0, 1'b0);
    push_miso(8'h5A);
    tx_valid = 1'b1; tx_data = 8'h5A;
    @(negedge clk); tx_valid = 1'b0; tx_data = '0;
    repeat (10) @(negedge clk);
    check("readout2_left", miso_q.size(), 0);
    SS_n = 1'b1;
    repeat (2) @(negedge clk);
    check("readout2_pending", exp_q.size(), 0);

    // Reset in the middle of a readout
    push_ev(1'b0, 1'b1, 10'h201);
    run_frame(1'b1, 10'h201, 10, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    push_ev(1'b0, 1'b1, 10'h3EE);
    run_frame(1'b1, 10'h3EE, 10, 1'b0, 1'b0);
    push_miso(8'h96);
    tx_valid = 1'b1; tx_data = 8'h96;
    @(negedge clk); tx_valid = 1'b0; tx_data = '0;
    repeat (2) @(negedge clk);
    check("mid_shift_busy", {31'd0, miso_busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_miso", {31'd0, MISO}, 0);
    check("arst_busy", {31'd0, miso_busy}, 0);
    check("arst_rx_valid", {31'd0, rx_valid}, 0);
    check("arst_frame_err", {31'd0, frame_err}, 0);
    check("arst_rx_data", {22'd0, rx_data}, 0);
    miso_q.delete();
    SS_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("arst_pending", exp_q.size(), 0);

    // Reset cleared rd_addr_rcvd: cmd 11 now lands in READ_ADD and is illegal
    push_ev(1'b1, 1'b1, 10'h3CD);
    run_frame(1'b1, 10'h3CD, 10, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("final_pending", exp_q.size(), 0);
    check("final_miso_q", miso_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
